// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin requester arbiter driving an n-way Mux select and capturing its output
// Define MUX_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module mux_rr_arbiter #(
    parameter int  SWITCH_BITS = 1,
    parameter int  DATA_WIDTH  = 8,
    localparam int N_CELL      = 1 << SWITCH_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CELL-1:0]      req_valid,
    output logic [N_CELL-1:0]      req_ready,
    output logic [SWITCH_BITS-1:0] sel_q,
    input  logic [DATA_WIDTH-1:0]  mux_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [SWITCH_BITS-1:0] out_src
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        OUTPUT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SWITCH_BITS-1:0] winner;
    logic                   any_req;

    assign any_req = |req_valid;

`ifdef MUX_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = N_CELL - 1; i >= 0; i--) begin
            if (req_valid[i]) winner = i[SWITCH_BITS-1:0];
        end
    end
`else
    logic [SWITCH_BITS-1:0] last;

    // Scan offsets high to low so the nearest set bit after `last` is assigned last and wins;
    // offset N_CELL wraps to `last` itself, giving it the lowest priority.
    always_comb begin
        logic [SWITCH_BITS-1:0] idx;
        winner = '0;
        idx    = '0;
        for (int i = N_CELL; i >= 1; i--) begin
            idx = last + i[SWITCH_BITS-1:0];
            if (req_valid[idx]) winner = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '1;
        end else if (state == SELECT && req_valid[sel_q]) begin
            last <= sel_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SELECT;
            SELECT:  state_nxt = req_valid[sel_q] ? OUTPUT : IDLE;
            OUTPUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sel_q only moves on IDLE->SELECT, so the Mux output is stable through the capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            req_ready <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (any_req) sel_q <= winner;
                end
                SELECT: begin
                    if (req_valid[sel_q]) begin
                        out_data         <= mux_o;
                        out_src          <= sel_q;
                        out_valid        <= 1'b1;
                        req_ready[sel_q] <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed vector bench for mux_rr_arbiter with a 4-input Mux model
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [1:0] sel_q;
    logic [7:0] mux_o;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic [7:0] mux_in [4];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] src;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    assign mux_o = mux_in[sel_q];

    mux_rr_arbiter #(.SWITCH_BITS(2), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sel_q     (sel_q),
        .mux_o     (mux_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the word handed off.
    task automatic do_word(input logic [3:0] mask, input logic [1:0] src, input logic [7:0] data);
        int         lat;
        logic [3:0] oh;
        oh        = 4'b0001 << src;
        req_valid = mask;
        out_ready = 1'b1;
        lat       = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        check("out_valid", {31'd0, out_valid}, 1);
        check("out_src", {30'd0, out_src}, {30'd0, src});
        check("out_data", {24'd0, out_data}, {24'd0, data});
        check("req_ready", {28'd0, req_ready}, {28'd0, oh});
        @(negedge clk);
        check("handoff_valid", {31'd0, out_valid}, 0);
        check("handoff_ready", {28'd0, req_ready}, 0);
    endtask

    initial begin
        mux_in[0] = 8'h11;
        mux_in[1] = 8'h22;
        mux_in[2] = 8'h33;
        mux_in[3] = 8'h44;

        vecs[0]  = '{4'b1111, 2'd0, 8'h11};
        vecs[1]  = '{4'b1111, 2'd1, 8'h22};
        vecs[2]  = '{4'b1111, 2'd2, 8'h33};
        vecs[3]  = '{4'b1111, 2'd3, 8'h44};
        vecs[4]  = '{4'b1111, 2'd0, 8'h11};
        vecs[5]  = '{4'b1010, 2'd1, 8'h22};
        vecs[6]  = '{4'b1010, 2'd3, 8'h44};
        vecs[7]  = '{4'b0100, 2'd2, 8'h33};
        vecs[8]  = '{4'b0100, 2'd2, 8'h33};
        vecs[9]  = '{4'b0001, 2'd0, 8'h11};
        vecs[10] = '{4'b1001, 2'd3, 8'h44};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            check("rst_req_ready", {28'd0, req_ready}, 0);
            check("rst_out_valid", {31'd0, out_valid}, 0);
            check("rst_sel_q", {30'd0, sel_q}, 0);
        end
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_src", {30'd0, out_src}, 0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        @(negedge clk);

`ifdef MUX_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) do_word(4'b1111, 2'd0, 8'h11);
        do_word(4'b1110, 2'd1, 8'h22);
        do_word(4'b1110, 2'd1, 8'h22);
        do_word(4'b1100, 2'd2, 8'h33);
`else
        for (int i = 0; i < 11; i++) do_word(vecs[i].mask, vecs[i].src, vecs[i].data);

        req_valid = 4'b1010;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid", {31'd0, out_valid}, 1);
        check("bp_src", {30'd0, out_src}, 1);
        check("bp_ready", {28'd0, req_ready}, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {16'd0, out_valid, out_src, out_data, req_ready},
                  {16'd0, 1'b1, 2'd1, 8'h22, 4'b0000});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {31'd0, out_valid}, 0);
        do_word(4'b1010, 2'd3, 8'h44);

        req_valid = 4'b0010;
        @(negedge clk);
        check("wd_sel_q", {30'd0, sel_q}, 1);
        req_valid = 4'b0000;
        @(negedge clk);
        check("wd_no_capture", {27'd0, out_valid, req_ready}, 0);
        @(negedge clk);
        check("wd_idle", {27'd0, out_valid, req_ready}, 0);
        do_word(4'b1011, 2'd0, 8'h11);
`endif

        mux_in[2] = 8'hA5;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        check("lat_sel_q", {30'd0, sel_q}, 2);
        check("lat_early", {27'd0, out_valid, req_ready}, 0);
        @(negedge clk);
        check("lat_capture", {17'd0, out_valid, out_src, out_data, req_ready},
              {17'd0, 1'b1, 2'd2, 8'hA5, 4'b0100});
        req_valid = 4'b0000;
        @(negedge clk);
        check("lat_pulse_end", {27'd0, out_valid, req_ready}, 0);
        mux_in[2] = 8'h33;

        req_valid = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_captured", {31'd0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", {17'd0, out_valid, out_src, out_data, req_ready, sel_q},
              {17'd0, 15'd0});
        @(negedge clk);
        rst_n = 1'b1;
        do_word(4'b1111, 2'd0, 8'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
